// File: rtl/mult32x32_pkg.sv
// Shared constants, state encoding and shift helper
// for the mult32x32_fast sequential multiplier.
package mult32x32_pkg;

    localparam int OPW  = 32;
    localparam int PW   = 64;
    localparam int HALF = 16;
    localparam int BYTE = 8;
    localparam int PPW  = HALF + BYTE;

    // Encoding: {active, i, j[1:0]} so the datapath
    // selects Ai/Bj straight from the state bits.
    typedef enum logic [3:0] {
        IDLE = 4'b0000,
        A0B0 = 4'b1000,
        A0B1 = 4'b1001,
        A0B2 = 4'b1010,
        A0B3 = 4'b1011,
        A1B0 = 4'b1100,
        A1B1 = 4'b1101,
        A1B2 = 4'b1110,
        A1B3 = 4'b1111
    } state_t;

    // Partial-product shift = 16*i + 8*j.
    function automatic logic [5:0] pp_shift(
        input logic [2:0] ij
    );
        logic [5:0] sh;
        sh = {1'b0, ij[2], 4'b0000} + {1'b0, ij[1:0], 3'b000};
        return sh;
    endfunction

endpackage

// File: rtl/mult32x32_fast_mult16x8.sv
// Combinational unsigned 16x8 -> 24 multiplier.
// Ports: i_a[15:0], i_b[7:0] operands; o_p[23:0] product.
module mult16x8
    import mult32x32_pkg::*;
(
    input  logic [HALF-1:0] i_a,
    input  logic [BYTE-1:0] i_b,
    output logic [PPW-1:0]  o_p
);

    assign o_p = {{BYTE{1'b0}}, i_a} * {{HALF{1'b0}}, i_b};

endmodule

// File: rtl/mult32x32_fast.sv
// Sequential unsigned 32x32 -> 64 multiplier using one 16x8 slice.
// Ports: clk, reset (async high), start, a, b -> busy, product.
// Define MULT32X32_FAST_SKIP_EN to skip zero upper operand halves.
module mult32x32_fast
    import mult32x32_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    output logic          busy,
    output logic [PW-1:0]  product
);

    state_t         r_state;
    state_t         w_next;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [PW-1:0]  r_product;

    logic           w_skip_a;
    logic           w_skip_b;
    logic [HALF-1:0] w_ai;
    logic [BYTE-1:0] w_bj;
    logic [PPW-1:0] w_pp;
    logic [PW-1:0]  w_addend;

`ifdef MULT32X32_FAST_SKIP_EN
    assign w_skip_a = (r_a[OPW-1:HALF] == '0);
    assign w_skip_b = (r_b[OPW-1:HALF] == '0);
`else
    assign w_skip_a = 1'b0;
    assign w_skip_b = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_next = A0B0;
            A0B0: w_next = A0B1;
            A0B1: begin
                if (!w_skip_b)     w_next = A0B2;
                else if (w_skip_a) w_next = IDLE;
                else               w_next = A1B0;
            end
            A0B2: w_next = A0B3;
            A0B3: w_next = w_skip_a ? IDLE : A1B0;
            A1B0: w_next = A1B1;
            A1B1: w_next = w_skip_b ? IDLE : A1B2;
            A1B2: w_next = A1B3;
            A1B3: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_ai = r_state[2] ? r_a[OPW-1:HALF] : r_a[HALF-1:0];

    always_comb begin
        w_bj = r_b[BYTE-1:0];
        unique case (r_state[1:0])
            2'd0: w_bj = r_b[BYTE-1:0];
            2'd1: w_bj = r_b[2*BYTE-1:BYTE];
            2'd2: w_bj = r_b[3*BYTE-1:2*BYTE];
            2'd3: w_bj = r_b[4*BYTE-1:3*BYTE];
            default: w_bj = r_b[BYTE-1:0];
        endcase
    end

    mult16x8 u_mul (
        .i_a (w_ai),
        .i_b (w_bj),
        .o_p (w_pp)
    );

    assign w_addend = {{(PW-PPW){1'b0}}, w_pp} << pp_shift(r_state[2:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_product <= '0;
        end else if (r_state == IDLE) begin
            if (start) begin
                r_a       <= a;
                r_b       <= b;
                r_product <= '0;
            end
        end else begin
            r_product <= r_product + w_addend;
        end
    end

    assign busy    = (r_state != IDLE);
    assign product = r_product;

endmodule

// File: tb/tb_mult32x32_fast.sv
// Scoreboard bench for mult32x32_fast: directed vectors,
// monitor checks product and busy length at each completion.
module tb_mult32x32_fast;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [63:0] product;

    typedef struct {
        logic [63:0] p;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mult32x32_fast dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .product (product)
    );

    always #5 clk = ~clk;

    function automatic int lat(input int fast);
`ifdef MULT32X32_FAST_SKIP_EN
        return fast;
`else
        return 8;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            cyc(1);
            k++;
        end
        if (busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: busy=%b want 0 after timeout", nm, busy);
        end
    endtask

    task automatic run(input logic [31:0] va, input logic [31:0] vb,
                       input logic [63:0] ep, input int el);
        exp_t e;
        wait_idle("pre_idle");
        a = va;
        b = vb;
        start = 1'b1;
        e.p = ep;
        e.lat = el;
        q.push_back(e);
        cyc(1);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_idle("op_done");
    endtask

    // Monitor: count busy cycles, check on each falling busy.
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0) begin
                cnt = 0;
                prev = 1'b0;
            end else begin
                if (busy === 1'b1) begin
                    cnt++;
                end else if (prev) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_done: product=%0h", product);
                    end else begin
                        e = q.pop_front();
                        chk("product", product, e.p);
                        chk("latency", 64'(cnt), 64'(e.lat));
                    end
                    cnt = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        exp_t e;
        int   k;
        reset = 1'b1;
        start = 1'b1;
        a = 32'd5;
        b = 32'd7;

        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("rst_busy", {63'b0, busy}, 64'd0);
            chk("rst_product", product, 64'd0);
        end
        start = 1'b0;
        reset = 1'b0;
        cyc(1);
        chk("post_rst_busy", {63'b0, busy}, 64'd0);
        chk("post_rst_product", product, 64'd0);

        run(32'd205961014, 32'd318947199, 64'd65690688518499786, 8);
        run(32'd46902, 32'd49023, 64'd2299276746, lat(2));
        run(32'h0001_0000, 32'd3, 64'h3_0000, lat(4));
        run(32'd3, 32'h0100_0000, 64'h300_0000, lat(4));

        // All-ones with start pulses while busy.
        wait_idle("pre_ones");
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
        e.p = 64'hFFFF_FFFE_0000_0001;
        e.lat = 8;
        q.push_back(e);
        cyc(1);
        start = 1'b0;
        cyc(2);
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle("ones_done");

        // Zero operands still take the minimum path.
        run(32'd0, 32'd0, 64'd0, lat(2));

        // Start held high: back-to-back ops, product cleared.
        wait_idle("pre_hold");
        a = 32'd3;
        b = 32'd5;
        start = 1'b1;
        e.p = 64'd15;
        e.lat = lat(2);
        q.push_back(e);
        cyc(1);
        wait_idle("hold_first");
        a = 32'd7;
        b = 32'd9;
        e.p = 64'd63;
        e.lat = lat(2);
        q.push_back(e);
        cyc(1);
        start = 1'b0;
        chk("hold_restart_busy", {63'b0, busy}, 64'd1);
        wait_idle("hold_second");

        // Reset mid-operation.
        wait_idle("pre_abort");
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("abort_busy_before", {63'b0, busy}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_product", product, 64'd0);
        cyc(1);
        reset = 1'b0;
        run(32'h0001_0000, 32'd3, 64'h3_0000, lat(4));
        run(32'd1000, 32'd1000, 64'd1000000, lat(2));

        k = 0;
        while (q.size() != 0 && k < 50) begin
            cyc(1);
            k++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d results outstanding", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
